// File: rtl/frame_len_queue.sv
// Per-class frame descriptor FIFO feeding the queue server: holds frame lengths in
// 16 B units and drains the head frame one unit per granted clock.
module frame_len_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned MIN_LEN = 4,
    parameter int unsigned MAX_LEN = 95
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_len,
    input  logic          bool_go,
    output logic [7:0]    pkt_len,
    output logic          tx_valid,
    output logic          tx_last,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [7:0]    drop_cnt
);

    typedef enum logic [1:0] {S_EMPTY, S_HEAD, S_XMIT} state_t;

    localparam logic [7:0]  MIN_L    = 8'(MIN_LEN);
    localparam logic [7:0]  MAX_L    = 8'(MAX_LEN);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [7:0]    mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [7:0]    residual_q, residual_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_last_q, tx_last_d;
    logic          wr_ok;
    logic          pop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pkt_len  = residual_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign drop_cnt = drop_q;

    // Uses the registered full flag, so a write racing a pop while full is rejected.
    assign wr_ok = wr_en && !full && (wr_len >= MIN_L) && (wr_len <= MAX_L);

    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        rd_ptr_d   = rd_ptr_q;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_EMPTY: begin
                if (count_q != '0) begin
                    residual_d = mem_q[rd_ptr_q];
                    state_d    = S_HEAD;
                end
            end
            S_HEAD, S_XMIT: begin
                if (bool_go) begin
                    tx_valid_d = 1'b1;
                    if (residual_q == 8'd1) begin
                        tx_last_d = 1'b1;
                        pop       = 1'b1;
                    end else begin
                        residual_d = residual_q - 8'd1;
                        state_d    = S_XMIT;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // On the final unit, load the next descriptor straight away when one is queued.
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (count_q > CNT_ONE) begin
                residual_d = mem_q[rd_ptr_d];
                state_d    = S_HEAD;
            end else begin
                residual_d = '0;
                state_d    = S_EMPTY;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        drop_d   = (wr_en && !wr_ok && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            residual_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
        end
    end

endmodule

// File: tb/tb_frame_len_queue.sv
// Directed bench for frame_len_queue: a scoreboard holds the expected per-unit
// (tx_last, pkt_len) stream and a monitor checks every transmitted unit.
module tb_frame_len_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_len = '0;
    logic       bool_go = 1'b0;
    logic [7:0] pkt_len;
    logic       tx_valid;
    logic       tx_last;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic [7:0] drop_cnt;

    int checks = 0;
    int failures = 0;
    logic [8:0] sb [$];

    frame_len_queue #(.DEPTH(8), .AW(3), .MIN_LEN(4), .MAX_LEN(95)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_len(wr_len), .bool_go(bool_go),
        .pkt_len(pkt_len), .tx_valid(tx_valid), .tx_last(tx_last), .full(full),
        .empty(empty), .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int len);
        wr_en  = 1'b1;
        wr_len = 8'(len);
        tick();
        wr_en  = 1'b0;
    endtask

    // Expected units of a frame: pkt_len after each unit, and after the last unit
    // the length of the frame that follows (0 when none is queued).
    task automatic push_frame(input int len, input int nxt);
        for (int i = 1; i <= len; i++) begin
            logic [7:0] post;
            post = (i < len) ? 8'(len - i) : 8'(nxt);
            sb.push_back({(i == len), post});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_unit", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("unit_tx_last", int'(tx_last), int'(e[8]));
                    chk("unit_pkt_len", int'(pkt_len), int'(e[7:0]));
                end
            end else if (tx_last) begin
                chk("tx_last_without_valid", 1, 0);
            end
        end
    end

    initial begin
        int lens [8];
        lens = '{95, 4, 7, 12, 9, 20, 6, 13};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pkt_len", int'(pkt_len), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_last", int'(tx_last), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        rst = 1'b0;
        tick();

        // T1: single minimum frame with the grant held high throughout
        bool_go = 1'b1;
        push_frame(4, 0);
        wr(4);
        chk("t1_count_after_wr", int'(count), 1);
        chk("t1_pkt_len_bubble", int'(pkt_len), 0);
        tick();
        chk("t1_pkt_len_loaded", int'(pkt_len), 4);
        for (int i = 3; i >= 0; i--) begin
            tick();
            chk("t1_pkt_len_drain", int'(pkt_len), i);
        end
        chk("t1_empty", int'(empty), 1);
        chk("t1_count", int'(count), 0);
        bool_go = 1'b0;
        tick();

        // T2: two frames back to back, no gap between them
        push_frame(5, 6);
        push_frame(6, 0);
        wr(5);
        wr(6);
        bool_go = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("t2_tx_valid_run", int'(tx_valid), 1);
        end
        tick();
        chk("t2_tx_valid_end", int'(tx_valid), 0);
        bool_go = 1'b0;
        tick();

        // T3: pause mid-frame and resume
        push_frame(8, 0);
        wr(8);
        tick();
        chk("t3_pkt_len_loaded", int'(pkt_len), 8);
        bool_go = 1'b1;
        repeat (3) tick();
        bool_go = 1'b0;
        chk("t3_pkt_len_paused", int'(pkt_len), 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_pause_hold", int'(pkt_len), 5);
            chk("t3_pause_idle", int'(tx_valid), 0);
        end
        bool_go = 1'b1;
        repeat (5) tick();
        chk("t3_final_last", int'(tx_last), 1);
        chk("t3_final_pkt_len", int'(pkt_len), 0);
        bool_go = 1'b0;
        tick();

        // T4: out-of-range lengths and a write while full are rejected
        wr(0);
        wr(3);
        wr(96);
        chk("t4_drop_range", int'(drop_cnt), 3);
        chk("t4_count_range", int'(count), 0);
        for (int l = 4; l <= 11; l++) begin
            push_frame(l, (l < 11) ? l + 1 : 0);
            wr(l);
        end
        chk("t4_count_full", int'(count), 8);
        chk("t4_full", int'(full), 1);
        wr(20);
        chk("t4_drop_full", int'(drop_cnt), 4);
        chk("t4_count_kept", int'(count), 8);
        chk("t4_head", int'(pkt_len), 4);
        bool_go = 1'b1;
        repeat (70) tick();
        bool_go = 1'b0;
        chk("t4_drained", int'(count), 0);

        // T5: refill across the pointer wrap, boundary lengths included
        for (int i = 0; i < 8; i++) begin
            push_frame(lens[i], (i < 7) ? lens[i+1] : 0);
            wr(lens[i]);
        end
        chk("t5_full", int'(full), 1);
        chk("t5_head", int'(pkt_len), 95);
        bool_go = 1'b1;
        repeat (175) tick();
        bool_go = 1'b0;
        chk("t5_empty", int'(empty), 1);
        tick();

        // T6: asynchronous reset in the middle of a frame
        push_frame(12, 0);
        wr(12);
        tick();
        bool_go = 1'b1;
        repeat (2) tick();
        bool_go = 1'b0;
        chk("t6_pkt_len_mid", int'(pkt_len), 10);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_pkt_len", int'(pkt_len), 0);
        chk("t6_rst_tx_valid", int'(tx_valid), 0);
        chk("t6_rst_tx_last", int'(tx_last), 0);
        chk("t6_rst_full", int'(full), 0);
        chk("t6_rst_empty", int'(empty), 1);
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_drop", int'(drop_cnt), 0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        push_frame(4, 0);
        wr(4);
        bool_go = 1'b1;
        repeat (6) tick();
        bool_go = 1'b0;
        chk("t6_fresh_empty", int'(empty), 1);
        chk("t6_fresh_tx_valid", int'(tx_valid), 0);
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
